// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  localparam int unsigned MAX_LS_STREAK_DEF = 4;
  localparam int unsigned TIMEOUT_CYC_DEF   = 255;
  localparam logic [63:0] DATA_ZERO         = 64'h0;
  localparam logic [7:0]  MASK_ALL          = 8'hFF;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of the arbiter; err_o exists only with MEM_TIMEOUT_EN.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr_i;
  logic [63:0] if_rdata_o;
  logic        if_valid_o;
  logic        ls_ren;
  logic        ls_wen;
  logic [63:0] ls_addr_i;
  logic [63:0] ls_wdata_i;
  logic [7:0]  ls_wmask_i;
  logic [63:0] ls_rdata_o;
  logic        ls_valid_o;
  logic        mem_req;
  logic        mem_wen;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic [63:0] mem_rdata_i;
  logic        mem_rvalid;
  logic        if_stall_o;
  logic        ls_stall_o;
`ifdef MEM_TIMEOUT_EN
  logic        err_o;
`endif

  // Arbiter side.
  modport slave (
    input  if_req, if_addr_i, ls_ren, ls_wen, ls_addr_i, ls_wdata_i, ls_wmask_i,
           mem_rdata_i, mem_rvalid,
    output if_rdata_o, if_valid_o, ls_rdata_o, ls_valid_o, mem_req, mem_wen,
           mem_addr_o, mem_wdata_o, mem_wmask_o, if_stall_o, ls_stall_o
`ifdef MEM_TIMEOUT_EN
    , output err_o
`endif
  );

  // Requester / memory side.
  modport master (
    output if_req, if_addr_i, ls_ren, ls_wen, ls_addr_i, ls_wdata_i, ls_wmask_i,
           mem_rdata_i, mem_rvalid,
    input  if_rdata_o, if_valid_o, ls_rdata_o, ls_valid_o, mem_req, mem_wen,
           mem_addr_o, mem_wdata_o, mem_wmask_o, if_stall_o, ls_stall_o
`ifdef MEM_TIMEOUT_EN
    , input err_o
`endif
  );
endinterface

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// Combinational grant selection: LS first, unless IF has waited out a full LS streak.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEF,
  parameter int unsigned SW            = cnt_width(MAX_LS_STREAK)
) (
  input  logic          if_req,
  input  logic          ls_pend,
  input  logic [SW-1:0] streak,
  output logic          grant_vld,
  output arb_owner_e    grant_own
);

  logic force_if;

  assign force_if = if_req && (streak == SW'(MAX_LS_STREAK));

  always_comb begin
    grant_vld = 1'b0;
    grant_own = OWN_IF;
    if (ls_pend && !force_if) begin
      grant_vld = 1'b1;
      grant_own = OWN_LS;
    end else if (if_req) begin
      grant_vld = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between fetch (IF) and load/store (LS), one transaction at a time.
// Define MEM_TIMEOUT_EN to add a WAIT watchdog with a sticky err_o flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEF
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SW = cnt_width(MAX_LS_STREAK);

  arb_state_e    state;
  arb_owner_e    owner;
  logic [SW-1:0] streak;
  logic          ls_pend;
  logic          grant_vld;
  arb_owner_e    grant_own;

  assign ls_pend       = bus.ls_ren | bus.ls_wen;
  assign bus.if_stall_o = bus.if_req & ~bus.if_valid_o;
  assign bus.ls_stall_o = ls_pend & ~bus.ls_valid_o;

  arb_prio_sel #(
    .MAX_LS_STREAK(MAX_LS_STREAK),
    .SW           (SW)
  ) u_prio_sel (
    .if_req   (bus.if_req),
    .ls_pend  (ls_pend),
    .streak   (streak),
    .grant_vld(grant_vld),
    .grant_own(grant_own)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = (cnt_width(TIMEOUT_CYC) < 8) ? 8 : cnt_width(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Counter holds WAIT cycles already spent, so the TIMEOUT_CYC-th WAIT cycle is the last.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ARB_IDLE;
      owner           <= OWN_IF;
      streak          <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_wen     <= 1'b0;
      bus.mem_addr_o  <= DATA_ZERO;
      bus.mem_wdata_o <= DATA_ZERO;
      bus.mem_wmask_o <= 8'h0;
      bus.if_valid_o  <= 1'b0;
      bus.ls_valid_o  <= 1'b0;
      bus.if_rdata_o  <= DATA_ZERO;
      bus.ls_rdata_o  <= DATA_ZERO;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt         <= '0;
      bus.err_o       <= 1'b0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_vld) begin
            owner       <= grant_own;
            bus.mem_req <= 1'b1;
            state       <= ARB_WAIT;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
            if (grant_own == OWN_LS) begin
              bus.mem_addr_o  <= bus.ls_addr_i;
              bus.mem_wdata_o <= bus.ls_wdata_i;
              bus.mem_wmask_o <= bus.ls_wmask_i;
              bus.mem_wen     <= bus.ls_wen;
              // Streak only tracks LS grants that actually held IF off.
              if (!bus.if_req)
                streak <= '0;
              else if (streak != SW'(MAX_LS_STREAK))
                streak <= streak + 1'b1;
            end else begin
              bus.mem_addr_o  <= bus.if_addr_i;
              bus.mem_wdata_o <= DATA_ZERO;
              bus.mem_wmask_o <= MASK_ALL;
              bus.mem_wen     <= 1'b0;
              streak          <= '0;
            end
          end
        end

        ARB_WAIT: begin
          if (bus.mem_rvalid) begin
            bus.mem_req <= 1'b0;
            bus.mem_wen <= 1'b0;
            state       <= ARB_RESP;
            if (owner == OWN_IF) begin
              bus.if_rdata_o <= bus.mem_rdata_i;
              bus.if_valid_o <= 1'b1;
            end else begin
              bus.ls_rdata_o <= bus.mem_rdata_i;
              bus.ls_valid_o <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            bus.mem_req <= 1'b0;
            bus.mem_wen <= 1'b0;
            bus.err_o   <= 1'b1;
            state       <= ARB_RESP;
            if (owner == OWN_IF) begin
              bus.if_rdata_o <= DATA_ZERO;
              bus.if_valid_o <= 1'b1;
            end else begin
              bus.ls_rdata_o <= DATA_ZERO;
              bus.ls_valid_o <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ARB_RESP: begin
          bus.if_valid_o <= 1'b0;
          bus.ls_valid_o <= 1'b0;
          state          <= ARB_IDLE;
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester agents, memory responder and a scoreboard of read data.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } ls_req_t;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    int          cyc;
  } grant_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if bus();

`ifdef MEM_TIMEOUT_EN
  mem_port_arbiter #(.MAX_LS_STREAK(4), .TIMEOUT_CYC(10)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  mem_port_arbiter #(.MAX_LS_STREAK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  logic [63:0] if_todo[$];
  ls_req_t     ls_todo[$];
  logic [63:0] if_exp[$];
  logic [63:0] ls_exp[$];
  grant_t      grant_log[$];

  int checks = 0;
  int failures = 0;
  int if_vcnt = 0, ls_vcnt = 0;
  int if_vcyc = 0, ls_vcyc = 0;
  int stab_err = 0;
  int rv_delay = 1;
  bit mem_auto = 1'b1;
  bit rv_manual = 1'b0;
  bit exp_zero = 1'b0;
  bit if_active = 1'b0, ls_active = 1'b0;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013_0000_0093;
    return {a[31:0] ^ 32'h5A5A_5A5A, ~a[31:0]};
  endfunction

  // Requester agents: load the next queued request, drop req once valid is seen.
  initial begin : agents
    logic [63:0] a;
    ls_req_t     r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_active && bus.if_valid_o) begin
          if_active  = 1'b0;
          bus.if_req = 1'b0;
        end
        if (!if_active && if_todo.size() > 0) begin
          a             = if_todo.pop_front();
          bus.if_addr_i = a;
          bus.if_req    = 1'b1;
          if_active     = 1'b1;
          if_exp.push_back(exp_zero ? 64'h0 : mem_model(a));
        end
        if (ls_active && bus.ls_valid_o) begin
          ls_active  = 1'b0;
          bus.ls_ren = 1'b0;
          bus.ls_wen = 1'b0;
        end
        if (!ls_active && ls_todo.size() > 0) begin
          r              = ls_todo.pop_front();
          bus.ls_addr_i  = r.addr;
          bus.ls_wdata_i = r.wdata;
          bus.ls_wmask_i = r.mask;
          bus.ls_wen     = r.wen;
          bus.ls_ren     = !r.wen;
          ls_active      = 1'b1;
          ls_exp.push_back(exp_zero ? 64'h0 : mem_model(r.addr));
        end
      end
    end
  end

  // Memory responder: logs each grant, watches payload stability, answers after rv_delay cycles.
  initial begin : responder
    int     wait_cnt;
    grant_t cur;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        wait_cnt++;
        if (wait_cnt == 1) begin
          cur.wen   = bus.mem_wen;
          cur.addr  = bus.mem_addr_o;
          cur.wdata = bus.mem_wdata_o;
          cur.mask  = bus.mem_wmask_o;
          cur.cyc   = cyc;
          grant_log.push_back(cur);
        end else if ({bus.mem_wen, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o} !==
                     {cur.wen, cur.addr, cur.wdata, cur.mask}) begin
          stab_err++;
        end
      end else begin
        wait_cnt = 0;
      end
      if (mem_auto) begin
        if (bus.mem_req && wait_cnt == rv_delay + 1) begin
          bus.mem_rvalid  = 1'b1;
          bus.mem_rdata_i = mem_model(bus.mem_addr_o);
        end else begin
          bus.mem_rvalid  = 1'b0;
          bus.mem_rdata_i = {$urandom, $urandom};
        end
      end else begin
        bus.mem_rvalid  = rv_manual;
        bus.mem_rdata_i = {$urandom, $urandom};
      end
    end
  end

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.if_valid_o) begin
        if_vcnt++;
        if_vcyc = cyc;
        checks++;
        if (if_exp.size() == 0) begin
          failures++;
          $display("FAIL if_valid_unexpected cyc=%0d got pulse, required none", cyc);
        end else begin
          e = if_exp.pop_front();
          if (bus.if_rdata_o !== e) begin
            failures++;
            $display("FAIL if_rdata got=%h required=%h", bus.if_rdata_o, e);
          end
        end
      end
      if (bus.ls_valid_o) begin
        ls_vcnt++;
        ls_vcyc = cyc;
        checks++;
        if (ls_exp.size() == 0) begin
          failures++;
          $display("FAIL ls_valid_unexpected cyc=%0d got pulse, required none", cyc);
        end else begin
          e = ls_exp.pop_front();
          if (bus.ls_rdata_o !== e) begin
            failures++;
            $display("FAIL ls_rdata got=%h required=%h", bus.ls_rdata_o, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((if_todo.size() > 0 || ls_todo.size() > 0 || if_active || ls_active) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain still busy after %0d cycles, required idle", name, n);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus.mem_req, bus.mem_wen, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o,
         bus.if_valid_o, bus.ls_valid_o, bus.if_rdata_o, bus.ls_rdata_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b wen=%b addr=%h wdata=%h mask=%h ifv=%b lsv=%b ifd=%h lsd=%h required all 0",
               bus.mem_req, bus.mem_wen, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o,
               bus.if_valid_o, bus.ls_valid_o, bus.if_rdata_o, bus.ls_rdata_o);
    end
`ifdef MEM_TIMEOUT_EN
    checks++;
    if (bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b required=0", bus.err_o);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    int c;
    rv_delay = 1;
    c = cyc;
    if_todo.push_back(64'h8000_0000);
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_wen, bus.mem_wmask_o, bus.mem_addr_o} !== {1'b1, 1'b0, 8'hFF, 64'h8000_0000}) begin
      failures++;
      $display("FAIL if_issue got req=%b wen=%b mask=%h addr=%h required 1 0 ff 8000_0000",
               bus.mem_req, bus.mem_wen, bus.mem_wmask_o, bus.mem_addr_o);
    end
    checks++;
    if (bus.if_stall_o !== 1'b1) begin
      failures++;
      $display("FAIL if_stall_c1 got=%b required=1", bus.if_stall_o);
    end
    tick();
    checks++;
    if ({bus.if_stall_o, bus.if_valid_o} !== 2'b10) begin
      failures++;
      $display("FAIL if_stall_c2 got stall=%b valid=%b required 1 0", bus.if_stall_o, bus.if_valid_o);
    end
    tick();
    checks++;
    if ({bus.if_valid_o, bus.if_stall_o, bus.if_rdata_o} !== {1'b1, 1'b0, 64'h0000_0013_0000_0093}) begin
      failures++;
      $display("FAIL if_valid_c3 got valid=%b stall=%b data=%h required 1 0 0000001300000093",
               bus.if_valid_o, bus.if_stall_o, bus.if_rdata_o);
    end
    drain("if_read", 20);
    checks++;
    if (if_vcyc !== c + 3) begin
      failures++;
      $display("FAIL if_latency got valid at cycle %0d required %0d", if_vcyc, c + 3);
    end
  endtask

  task automatic test_simultaneous();
    int     g;
    ls_req_t r;
    g = grant_log.size();
    r = '{wen: 1'b0, addr: 64'h8000_1000, wdata: 64'h0, mask: 8'hFF};
    if_todo.push_back(64'h8000_0100);
    ls_todo.push_back(r);
    drain("simul", 40);
    checks++;
    if (grant_log.size() !== g + 2) begin
      failures++;
      $display("FAIL simul_grants got=%0d required=%0d", grant_log.size() - g, 2);
    end else begin
      checks++;
      if ({grant_log[g].wen, grant_log[g].addr} !== {1'b0, 64'h8000_1000}) begin
        failures++;
        $display("FAIL simul_first got wen=%b addr=%h required 0 8000_1000", grant_log[g].wen, grant_log[g].addr);
      end
      checks++;
      if (grant_log[g+1].addr !== 64'h8000_0100) begin
        failures++;
        $display("FAIL simul_second got addr=%h required 8000_0100", grant_log[g+1].addr);
      end
      checks++;
      if (grant_log[g+1].cyc !== ls_vcyc + 2) begin
        failures++;
        $display("FAIL simul_if_gap got mem_req cycle %0d required %0d", grant_log[g+1].cyc, ls_vcyc + 2);
      end
    end
  endtask

  task automatic test_store();
    int      g, s0, v0;
    ls_req_t r;
    rv_delay = 5;
    g  = grant_log.size();
    s0 = stab_err;
    v0 = ls_vcnt;
    r  = '{wen: 1'b1, addr: 64'h8000_2004, wdata: 64'hDEAD_BEEF, mask: 8'h0F};
    ls_todo.push_back(r);
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_wen, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o} !==
        {1'b1, 1'b1, 64'h8000_2004, 64'hDEAD_BEEF, 8'h0F}) begin
      failures++;
      $display("FAIL store_issue got req=%b wen=%b addr=%h wdata=%h mask=%h required 1 1 8000_2004 deadbeef 0f",
               bus.mem_req, bus.mem_wen, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o);
    end
    checks++;
    if (bus.ls_stall_o !== 1'b1) begin
      failures++;
      $display("FAIL store_stall got=%b required=1", bus.ls_stall_o);
    end
    drain("store", 40);
    checks++;
    if (stab_err !== s0) begin
      failures++;
      $display("FAIL store_stable got %0d unstable cycles required 0", stab_err - s0);
    end
    checks++;
    if (ls_vcnt !== v0 + 1) begin
      failures++;
      $display("FAIL store_pulses got=%0d required=1", ls_vcnt - v0);
    end
    checks++;
    if (grant_log.size() !== g + 1 || ls_vcyc - grant_log[grant_log.size()-1].cyc !== 6) begin
      failures++;
      $display("FAIL store_latency got grants=%0d valid-req=%0d required 1 and 6",
               grant_log.size() - g, ls_vcyc - grant_log[grant_log.size()-1].cyc);
    end
    rv_delay = 1;
  endtask

  task automatic test_starvation();
    int      g;
    bit      exp_if[9];
    bit      obs_if;
    ls_req_t r;
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    g = grant_log.size();
    if_todo.push_back(64'h8000_0200);
    if_todo.push_back(64'h8000_0204);
    for (int i = 0; i < 7; i++) begin
      r = '{wen: 1'b0, addr: 64'h8000_3000 + 64'(8 * i), wdata: 64'h0, mask: 8'hFF};
      ls_todo.push_back(r);
    end
    drain("starve", 200);
    checks++;
    if (grant_log.size() !== g + 9) begin
      failures++;
      $display("FAIL starve_grants got=%0d required=9", grant_log.size() - g);
    end else begin
      for (int i = 0; i < 9; i++) begin
        obs_if = (grant_log[g+i].addr[15:12] == 4'h0);
        checks++;
        if (obs_if !== exp_if[i]) begin
          failures++;
          $display("FAIL starve_order grant %0d got is_if=%b required is_if=%b", i, obs_if, exp_if[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int n, v0;
    mem_auto  = 1'b0;
    rv_manual = 1'b0;
    if_todo.push_back(64'h8000_0300);
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL rstwait_req got no mem_req in %0d cycles required mem_req=1", n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_wen, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o,
         bus.if_valid_o, bus.ls_valid_o, bus.if_rdata_o, bus.ls_rdata_o} !== '0) begin
      failures++;
      $display("FAIL rstwait_outputs got req=%b wen=%b addr=%h wdata=%h mask=%h ifv=%b lsv=%b ifd=%h lsd=%h required all 0",
               bus.mem_req, bus.mem_wen, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o,
               bus.if_valid_o, bus.ls_valid_o, bus.if_rdata_o, bus.ls_rdata_o);
    end
    if_todo.delete();
    if_exp.delete();
    if_active  = 1'b0;
    bus.if_req = 1'b0;
    tick();
    rst = 1'b0;
    v0 = if_vcnt + ls_vcnt;
    repeat (2) tick();
    rv_manual = 1'b1;
    tick();
    rv_manual = 1'b0;
    repeat (4) tick();
    checks++;
    if ((if_vcnt + ls_vcnt) !== v0) begin
      failures++;
      $display("FAIL rstwait_late_rvalid got %0d valid pulses required 0", if_vcnt + ls_vcnt - v0);
    end
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstwait_idle got mem_req=%b required 0", bus.mem_req);
    end
    mem_auto = 1'b1;
    repeat (2) tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int      g, n, v0;
    ls_req_t r;
    mem_auto  = 1'b0;
    rv_manual = 1'b0;
    exp_zero  = 1'b1;
    g  = grant_log.size();
    v0 = ls_vcnt;
    r  = '{wen: 1'b0, addr: 64'h8000_4000, wdata: 64'h0, mask: 8'hFF};
    ls_todo.push_back(r);
    n = 0;
    while (ls_vcnt == v0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40 || grant_log.size() !== g + 1) begin
      failures++;
      $display("FAIL tmo_pulse got no timeout response in %0d cycles required one", n);
    end else begin
      checks++;
      if (ls_vcyc - grant_log[g].cyc !== 10) begin
        failures++;
        $display("FAIL tmo_latency got %0d WAIT cycles required 10", ls_vcyc - grant_log[g].cyc);
      end
    end
    drain("tmo", 20);
    exp_zero = 1'b0;
    repeat (5) tick();
    checks++;
    if ({bus.err_o, bus.mem_req} !== 2'b10) begin
      failures++;
      $display("FAIL tmo_sticky got err=%b req=%b required 1 0", bus.err_o, bus.mem_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got err=%b required 0", bus.err_o);
    end
    mem_auto = 1'b1;
    repeat (2) tick();
  endtask
`endif

  initial begin : main
    bus.if_req      = 1'b0;
    bus.if_addr_i   = 64'h0;
    bus.ls_ren      = 1'b0;
    bus.ls_wen      = 1'b0;
    bus.ls_addr_i   = 64'h0;
    bus.ls_wdata_i  = 64'h0;
    bus.ls_wmask_i  = 8'h0;
    bus.mem_rdata_i = 64'h0;
    bus.mem_rvalid  = 1'b0;

    test_reset();
    test_if_read();
    test_simultaneous();
    test_store();
    test_starvation();
    test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif

    checks++;
    if (if_exp.size() != 0 || ls_exp.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations got if=%0d ls=%0d required 0 0", if_exp.size(), ls_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog simulation exceeded time limit, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single 64-bit memory port between two requesters: instruction fetch (IF) and load/store (LS, driven by decoded load/store requests from EX/MEM).
- One outstanding transaction at a time.
- LS has fixed priority over IF, with a starvation limit that guarantees IF progress.
- Produces per-requester stall signals for the pipeline controller.

Parameters:
- MAX_LS_STREAK, 4: max consecutive LS grants while IF is pending before IF is forced.
- TIMEOUT_CYC, 255: watchdog limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_valid
- if_addr_i  in  64  fetch address
- if_rdata_o  out  64  fetch read data
- if_valid_o  out  1  one-cycle fetch completion pulse
- ls_ren  in  1  load request; held until ls_valid
- ls_wen  in  1  store request; held until ls_valid
- ls_addr_i  in  64  load/store address
- ls_wdata_i  in  64  store data
- ls_wmask_i  in  8  store byte mask
- ls_rdata_o  out  64  load read data
- ls_valid_o  out  1  one-cycle LS completion pulse
- mem_req  out  1  memory request, held until mem_rvalid
- mem_wen  out  1  write enable to memory
- mem_addr_o  out  64  memory address
- mem_wdata_o  out  64  memory write data
- mem_wmask_o  out  8  memory byte mask
- mem_rdata_i  in  64  memory read data
- mem_rvalid  in  1  memory completion; any latency of 1 or more cycles after mem_req
- if_stall_o  out  1  equals if_req & ~if_valid_o
- ls_stall_o  out  1  equals (ls_ren|ls_wen) & ~ls_valid_o
- err_o  out  1  sticky timeout flag; exists only when MEM_TIMEOUT_EN is defined

Behaviour:
- Reset:
  - rst=1 asynchronously forces state IDLE and owner=IF.
  - streak counter resets to 0.
  - All outputs reset to 0: mem_req, mem_wen, mem_addr_o, mem_wdata_o, mem_wmask_o, if_valid_o, ls_valid_o, if_rdata_o, ls_rdata_o, err_o.
  - Reset mid-transaction abandons it; a late mem_rvalid arriving in IDLE is ignored.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: samples requests and arbitrates.
  - LS pending = ls_ren|ls_wen. ls_ren and ls_wen both set is treated as a store.
  - Grant LS if LS is pending and not (if_req && streak==MAX_LS_STREAK). Otherwise grant IF if if_req.
  - On grant: register owner, mem_addr_o, mem_wdata_o, mem_wmask_o and mem_wen; mem_wen=1 only for an LS store.
  - Set mem_req=1 and go to WAIT. No request: stay in IDLE.
  - IF grants always issue as reads with mask 8'hFF.
- WAIT:
  - mem_req and the payload registers stay stable until mem_rvalid.
  - On mem_rvalid: register mem_rdata_i into the owner's rdata output, clear mem_req and mem_wen, go to RESP.
- RESP:
  - The owner's valid output is 1 for exactly this one cycle. Next state is unconditionally IDLE.
  - Requests seen during RESP are ignored. Requesters drop req on the edge that samples valid=1.
  - The other rdata output holds its last value.
- Latency: request in IDLE at cycle 0, mem_req high from cycle 1. If mem_rvalid arrives at cycle k, valid is high at cycle k+1 and IDLE resumes at k+2. Minimum total is 3 cycles.
- Streak counter:
  - Increments, saturating at MAX_LS_STREAK, on an LS grant while if_req=1.
  - Clears on any IF grant, and on an LS grant while if_req=0.
- Stores return mem_rdata_i into ls_rdata_o as well; the value is don't-care for the requester.
- Owner and payload registers cannot change in WAIT or RESP: requester input changes there have no effect.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter counts WAIT cycles.
  - When it reaches TIMEOUT_CYC without mem_rvalid: go to RESP, owner's rdata=64'h0, set err_o sticky until rst.
  - The counter clears on entering WAIT.
- MEM_TIMEOUT_EN undefined: there is no counter and no err_o port. WAIT waits indefinitely.

Decomposition:
- Shared defines file holds:
  - state encodings (ARB_IDLE=2'd0, ARB_WAIT=2'd1, ARB_RESP=2'd2)
  - owner encoding (OWN_IF=1'b0, OWN_LS=1'b1)
  - default MAX_LS_STREAK and TIMEOUT_CYC
  - the 64'h0 / 8'hFF constants
- One sub-module is natural: arb_prio_sel. It is combinational and computes the grant from if_req, ls pending, streak and MAX_LS_STREAK. The FSM and registers stay in the top.

Test Plan:
- Reset mid-WAIT: assert rst after mem_req=1 -> all outputs 0 immediately. A mem_rvalid pulse 2 cycles later produces no valid.
- IF-only read: if_req, addr 64'h8000_0000; mem_rvalid 1 cycle after mem_req with rdata 64'h0000_0013_0000_0093 -> if_valid_o high at cycle 3 with that data; if_stall_o high cycles 0-2.
- Simultaneous: if_req and ls_ren at 64'h8000_1000 in the same cycle -> LS served first (mem_wen=0). IF served immediately after LS RESP.
- Store: ls_wen, addr 64'h8000_2004, wdata 64'hDEAD_BEEF, mask 8'h0F -> mem_wen=1 and payload stable across a 5-cycle mem_rvalid delay. Single ls_valid_o pulse.
- Starvation: IF held high, LS re-requesting continuously -> grant order is LS, LS, LS, LS, IF (MAX_LS_STREAK=4), then the streak restarts.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYC=10): mem_rvalid never asserted -> ls_valid_o pulses after 10 WAIT cycles with rdata=0 and err_o=1, which persists until rst.
